picorv32_posted_write_buffer: RTL and testbench

Posted-write buffer between the PicoRV32 native memory interface and the PicoRV32-to-FreeAHB adapter. Core writes are acknowledged after one cycle and queued in a FIFO, so the core does not wait for the AHB transfer. Reads are held until every queued write has drained, which keeps program order, and are then passed through to the adapter. Both sides use the PicoRV32 native valid/ready protocol.

---
 rtl/picorv32_posted_write_buffer.sv | 191 +++++++++++++++++++
 tb/tb_picorv32_posted_write_buffer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/picorv32_posted_write_buffer.sv
// Posted-write buffer between the PicoRV32 native memory port and the AHB adapter.
// Writes are acked at once and queued; reads wait until the queue has drained.
module picorv32_posted_write_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    up_mem_valid,
  input  logic                    up_mem_instr,
  input  logic [31:0]             up_mem_addr,
  input  logic [31:0]             up_mem_wdata,
  input  logic [3:0]              up_mem_wstrb,
  output logic                    up_mem_ready,
  output logic [31:0]             up_mem_rdata,
  output logic                    dn_mem_valid,
  output logic                    dn_mem_instr,
  output logic [31:0]             dn_mem_addr,
  output logic [31:0]             dn_mem_wdata,
  output logic [3:0]              dn_mem_wstrb,
  input  logic                    dn_mem_ready,
  input  logic [31:0]             dn_mem_rdata,
  output logic [$clog2(DEPTH):0]  wb_count,
  output logic                    wb_empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_READ, ST_RESP} state_e;

  typedef struct packed {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } wb_entry_t;

  state_e          state_q, state_d;
  wb_entry_t       mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            empty_q, empty_d;
  logic            rd_pend_q, rd_pend_d;
  logic            rd_instr_q, rd_instr_d;
  logic [31:0]     rd_addr_q, rd_addr_d;
  logic            up_ready_q, up_ready_d;
  logic [31:0]     up_rdata_q, up_rdata_d;
  logic            dn_valid_q, dn_valid_d;
  logic            dn_instr_q, dn_instr_d;
  logic [31:0]     dn_addr_q, dn_addr_d;
  logic [31:0]     dn_wdata_q, dn_wdata_d;
  logic [3:0]      dn_wstrb_q, dn_wstrb_d;

  logic            full_c, accept_c, push_c, rd_acc_c, pop_c;
  wb_entry_t       head_c, push_entry_c;

  // Requests are taken only outside the ack cycle and while no read is pending.
  assign full_c       = (count_q == CW'(DEPTH));
  assign accept_c     = up_mem_valid && !up_ready_q && !rd_pend_q;
  assign push_c       = accept_c && (up_mem_wstrb != 4'b0000) && !full_c;
  assign rd_acc_c     = accept_c && (up_mem_wstrb == 4'b0000);
  assign head_c       = mem_q[rd_ptr_q];
  assign push_entry_c = '{instr: up_mem_instr, addr: up_mem_addr,
                          wdata: up_mem_wdata, wstrb: up_mem_wstrb};

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rd_pend_d  = rd_pend_q;
    rd_instr_d = rd_instr_q;
    rd_addr_d  = rd_addr_q;
    up_ready_d = 1'b0;
    up_rdata_d = up_rdata_q;
    dn_valid_d = dn_valid_q;
    dn_instr_d = dn_instr_q;
    dn_addr_d  = dn_addr_q;
    dn_wdata_d = dn_wdata_q;
    dn_wstrb_d = dn_wstrb_q;
    pop_c      = 1'b0;

    if (push_c) begin
      up_ready_d = 1'b1;
      wr_ptr_d   = wr_ptr_q + PW'(1);
    end
    if (rd_acc_c) begin
      rd_pend_d  = 1'b1;
      rd_addr_d  = up_mem_addr;
      rd_instr_d = up_mem_instr;
    end

    // Draining beats a pending read, so a read never overtakes a queued write.
    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          state_d    = ST_DRAIN;
          dn_valid_d = 1'b1;
          dn_instr_d = head_c.instr;
          dn_addr_d  = head_c.addr;
          dn_wdata_d = head_c.wdata;
          dn_wstrb_d = head_c.wstrb;
        end else if (rd_pend_q) begin
          state_d    = ST_READ;
          dn_valid_d = 1'b1;
          dn_instr_d = rd_instr_q;
          dn_addr_d  = rd_addr_q;
          dn_wdata_d = '0;
          dn_wstrb_d = '0;
        end
      end
      ST_DRAIN: begin
        if (dn_mem_ready) begin
          pop_c      = 1'b1;
          rd_ptr_d   = rd_ptr_q + PW'(1);
          dn_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      ST_READ: begin
        if (dn_mem_ready) begin
          up_rdata_d = dn_mem_rdata;
          up_ready_d = 1'b1;
          dn_valid_d = 1'b0;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        rd_pend_d = 1'b0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    count_d = count_q + CW'(push_c) - CW'(pop_c);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      rd_pend_q  <= 1'b0;
      rd_instr_q <= 1'b0;
      rd_addr_q  <= '0;
      up_ready_q <= 1'b0;
      up_rdata_q <= '0;
      dn_valid_q <= 1'b0;
      dn_instr_q <= 1'b0;
      dn_addr_q  <= '0;
      dn_wdata_q <= '0;
      dn_wstrb_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      rd_pend_q  <= rd_pend_d;
      rd_instr_q <= rd_instr_d;
      rd_addr_q  <= rd_addr_d;
      up_ready_q <= up_ready_d;
      up_rdata_q <= up_rdata_d;
      dn_valid_q <= dn_valid_d;
      dn_instr_q <= dn_instr_d;
      dn_addr_q  <= dn_addr_d;
      dn_wdata_q <= dn_wdata_d;
      dn_wstrb_q <= dn_wstrb_d;
    end
  end

  // Entry storage needs no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= push_entry_c;
    end
  end

  assign up_mem_ready = up_ready_q;
  assign up_mem_rdata = up_rdata_q;
  assign dn_mem_valid = dn_valid_q;
  assign dn_mem_instr = dn_instr_q;
  assign dn_mem_addr  = dn_addr_q;
  assign dn_mem_wdata = dn_wdata_q;
  assign dn_mem_wstrb = dn_wstrb_q;
  assign wb_count     = count_q;
  assign wb_empty     = empty_q;

endmodule

// File: tb/tb_picorv32_posted_write_buffer.sv
// Randomized self-checking bench for picorv32_posted_write_buffer: a transaction-level
// model of expected downstream order and read data, with an adapter model driving dn_mem_ready.
module tb_picorv32_posted_write_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk, resetn;
  logic          up_mem_valid, up_mem_instr, up_mem_ready;
  logic [31:0]   up_mem_addr, up_mem_wdata, up_mem_rdata;
  logic [3:0]    up_mem_wstrb;
  logic          dn_mem_valid, dn_mem_instr, dn_mem_ready;
  logic [31:0]   dn_mem_addr, dn_mem_wdata, dn_mem_rdata;
  logic [3:0]    dn_mem_wstrb;
  logic [CW-1:0] wb_count;
  logic          wb_empty;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        instr;
  } txn_t;

  txn_t        exp_q[$];
  txn_t        obs_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          amode    = 0;   // 0 stalled, 1 zero-wait, 2 random wait
  logic [31:0] next_rdata = '0;
  logic [31:0] last_rdata = '0;
  int          stable_err, spacing_err, pulse_err, max_count;

  picorv32_posted_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn),
    .up_mem_valid(up_mem_valid), .up_mem_instr(up_mem_instr), .up_mem_addr(up_mem_addr),
    .up_mem_wdata(up_mem_wdata), .up_mem_wstrb(up_mem_wstrb), .up_mem_ready(up_mem_ready),
    .up_mem_rdata(up_mem_rdata),
    .dn_mem_valid(dn_mem_valid), .dn_mem_instr(dn_mem_instr), .dn_mem_addr(dn_mem_addr),
    .dn_mem_wdata(dn_mem_wdata), .dn_mem_wstrb(dn_mem_wstrb), .dn_mem_ready(dn_mem_ready),
    .dn_mem_rdata(dn_mem_rdata),
    .wb_count(wb_count), .wb_empty(wb_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Adapter model: one-cycle ready pulses, read data supplied from next_rdata.
  initial begin
    dn_mem_ready = 1'b0;
    dn_mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (dn_mem_ready) dn_mem_ready = 1'b0;
      else if (dn_mem_valid && resetn &&
               (amode == 1 || (amode == 2 && $urandom_range(0, 2) == 0))) begin
        dn_mem_ready = 1'b1;
        dn_mem_rdata = (dn_mem_wstrb == 4'b0000) ? next_rdata : $urandom;
      end
    end
  end

  // Monitor: records completed downstream transactions and protocol violations.
  initial begin
    logic        pv, pack, pur;
    logic [68:0] pf;
    pv = 0; pack = 0; pur = 0; pf = '0;
    forever begin
      @(negedge clk);
      if (dn_mem_valid && pv && pf != {dn_mem_instr, dn_mem_addr, dn_mem_wdata, dn_mem_wstrb})
        stable_err++;
      if (dn_mem_valid && pack) spacing_err++;
      if (up_mem_ready && pur) pulse_err++;
      if (dn_mem_valid && dn_mem_ready)
        obs_q.push_back('{addr: dn_mem_addr, wdata: dn_mem_wdata,
                          wstrb: dn_mem_wstrb, instr: dn_mem_instr});
      if (int'(wb_count) > max_count) max_count = int'(wb_count);
      pv   = dn_mem_valid;
      pack = dn_mem_valid && dn_mem_ready;
      pur  = up_mem_ready;
      pf   = {dn_mem_instr, dn_mem_addr, dn_mem_wdata, dn_mem_wstrb};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int seq_diff();
    int n;
    n = (exp_q.size() < obs_q.size()) ? exp_q.size() : obs_q.size();
    for (int i = 0; i < n; i++)
      if (exp_q[i].addr !== obs_q[i].addr || exp_q[i].wstrb !== obs_q[i].wstrb ||
          exp_q[i].instr !== obs_q[i].instr ||
          (exp_q[i].wstrb != 4'b0000 && exp_q[i].wdata !== obs_q[i].wdata))
        return i;
    if (exp_q.size() != obs_q.size()) return n;
    return -1;
  endfunction

  task automatic clear_scoreboard();
    exp_q.delete(); obs_q.delete();
    stable_err = 0; spacing_err = 0; pulse_err = 0; max_count = 0;
  endtask

  task automatic apply_reset();
    resetn = 1'b0; up_mem_valid = 0; up_mem_instr = 0;
    up_mem_addr = '0; up_mem_wdata = '0; up_mem_wstrb = '0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    last_rdata = '0;
    clear_scoreboard();
  endtask

  // Core-side request: hold valid until ready; lat = cycles from valid to ready (-1 on timeout).
  task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic ins, output int lat, output logic [31:0] rd);
    exp_q.push_back('{addr: a, wdata: d, wstrb: s, instr: ins});
    @(posedge clk); #1;
    up_mem_valid = 1; up_mem_addr = a; up_mem_wdata = d; up_mem_wstrb = s; up_mem_instr = ins;
    lat = -1; rd = '0;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk); #1;
      if (up_mem_ready) begin lat = i; rd = up_mem_rdata; break; end
    end
    up_mem_valid = 0;
  endtask

  task automatic wait_drain(output bit ok);
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (wb_empty && !dn_mem_valid) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (up_mem_ready !== 1'b0 || up_mem_rdata !== '0) begin n_fail++;
      $display("FAIL reset_up: got ready=%b rdata=%h, expected 0/0", up_mem_ready, up_mem_rdata); end
    n_checks++; if (dn_mem_valid !== 1'b0 || dn_mem_instr !== 1'b0) begin n_fail++;
      $display("FAIL reset_dn_valid: got valid=%b instr=%b, expected 0/0", dn_mem_valid, dn_mem_instr); end
    n_checks++; if ({dn_mem_addr, dn_mem_wdata, dn_mem_wstrb} !== '0) begin n_fail++;
      $display("FAIL reset_dn_fields: got %h/%h/%h, expected 0", dn_mem_addr, dn_mem_wdata, dn_mem_wstrb); end
    n_checks++; if (wb_count !== '0 || wb_empty !== 1'b1) begin n_fail++;
      $display("FAIL reset_status: got count=%0d empty=%b, expected 0/1", wb_count, wb_empty); end
  endtask

  task automatic test_write_stalled();
    int lat; logic [31:0] rd; bit ok; int d;
    clear_scoreboard(); amode = 0;
    do_req(32'h8000_0000, 32'hF0FF_0FAA, 4'b1100, 1'b0, lat, rd);
    n_checks++; if (lat !== 1) begin n_fail++;
      $display("FAIL ws_ack_latency: got %0d expected 1", lat); end
    n_checks++; if (wb_count !== CW'(1)) begin n_fail++;
      $display("FAIL ws_count: got %0d expected 1", wb_count); end
    repeat (6) @(posedge clk); #1;
    n_checks++; if (dn_mem_valid !== 1'b1) begin n_fail++;
      $display("FAIL ws_dn_valid: got %b expected 1", dn_mem_valid); end
    n_checks++; if (dn_mem_addr !== 32'h8000_0000 || dn_mem_wdata !== 32'hF0FF_0FAA ||
                    dn_mem_wstrb !== 4'b1100 || dn_mem_instr !== 1'b0) begin n_fail++;
      $display("FAIL ws_dn_fields: got %h/%h/%b/%b expected 80000000/f0ff0faa/1100/0",
               dn_mem_addr, dn_mem_wdata, dn_mem_wstrb, dn_mem_instr); end
    amode = 1;
    wait_drain(ok);
    d = seq_diff();
    n_checks++; if (!ok || d != -1 || stable_err != 0) begin n_fail++;
      $display("FAIL ws_drain: got drained=%0d diff_idx=%0d unstable=%0d expected 1/-1/0", ok, d, stable_err); end
  endtask

  task automatic test_fill_full();
    int lat; logic [31:0] rd; bit ok, early, acked; int obs_at_ack, d; logic [31:0] a5, d5;
    clear_scoreboard(); amode = 0;
    for (int i = 0; i < 4; i++) begin
      do_req($urandom & ~32'h3, $urandom, 4'b1111, 1'b0, lat, rd);
      n_checks++; if (lat !== 1) begin n_fail++;
        $display("FAIL ff_ack_%0d: got latency %0d expected 1", i, lat); end
    end
    n_checks++; if (wb_count !== CW'(4)) begin n_fail++;
      $display("FAIL ff_count_full: got %0d expected 4", wb_count); end
    a5 = $urandom & ~32'h3; d5 = $urandom;
    exp_q.push_back('{addr: a5, wdata: d5, wstrb: 4'b0011, instr: 1'b0});
    @(posedge clk); #1;
    up_mem_valid = 1; up_mem_addr = a5; up_mem_wdata = d5; up_mem_wstrb = 4'b0011; up_mem_instr = 0;
    early = 0;
    repeat (8) begin @(posedge clk); #1; if (up_mem_ready) early = 1; end
    n_checks++; if (early !== 1'b0) begin n_fail++;
      $display("FAIL ff_stall: got early ack=%b expected 0", early); end
    amode = 1; acked = 0; obs_at_ack = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (up_mem_ready) begin acked = 1; obs_at_ack = obs_q.size(); break; end
    end
    up_mem_valid = 0;
    n_checks++; if (!acked || obs_at_ack < 1) begin n_fail++;
      $display("FAIL ff_fifth_ack: got acked=%0d pops_before=%0d expected 1/>=1", acked, obs_at_ack); end
    wait_drain(ok);
    d = seq_diff();
    n_checks++; if (!ok || d != -1 || max_count != 4) begin n_fail++;
      $display("FAIL ff_order: got drained=%0d diff_idx=%0d max_count=%0d expected 1/-1/4", ok, d, max_count); end
  endtask

  task automatic test_read_after_write();
    int lat; logic [31:0] rd; bit ok; int d;
    clear_scoreboard(); amode = 2;
    for (int i = 0; i < 2; i++) do_req($urandom & ~32'h3, $urandom, 4'($urandom_range(1, 15)), 1'b0, lat, rd);
    next_rdata = 32'hAAAA_FFFF;
    do_req(32'h8000_0000, 32'h0, 4'b0000, 1'b0, lat, rd);
    last_rdata = 32'hAAAA_FFFF;
    n_checks++; if (lat < 0 || rd !== 32'hAAAA_FFFF) begin n_fail++;
      $display("FAIL raw_rdata: got lat=%0d rdata=%h expected >0/aaaaffff", lat, rd); end
    wait_drain(ok);
    d = seq_diff();
    n_checks++; if (!ok || d != -1 || pulse_err != 0) begin n_fail++;
      $display("FAIL raw_order: got drained=%0d diff_idx=%0d wide_pulses=%0d expected 1/-1/0", ok, d, pulse_err); end
  endtask

  task automatic test_read_empty();
    int lat; logic [31:0] rd; bit ok;
    clear_scoreboard(); amode = 1;
    for (int i = 0; i < 3; i++) begin
      next_rdata = $urandom;
      do_req($urandom & ~32'h3, 32'h0, 4'b0000, 1'($urandom_range(0, 1)), lat, rd);
      last_rdata = next_rdata;
      n_checks++; if (lat !== 3 || rd !== next_rdata) begin n_fail++;
        $display("FAIL re_latency_%0d: got lat=%0d rdata=%h expected 3/%h", i, lat, rd, next_rdata); end
    end
    wait_drain(ok);
    n_checks++; if (!ok || spacing_err != 0 || seq_diff() != -1) begin n_fail++;
      $display("FAIL re_spacing: got drained=%0d back_to_back=%0d expected 1/0", ok, spacing_err); end
  endtask

  task automatic test_wrap();
    int lat; logic [31:0] rd; bit ok; int d;
    clear_scoreboard(); amode = 2;
    for (int i = 0; i < 10; i++) begin
      do_req($urandom, $urandom, 4'($urandom_range(1, 15)), 1'b0, lat, rd);
      n_checks++; if (lat < 1) begin n_fail++;
        $display("FAIL wrap_ack_%0d: got latency %0d expected >=1", i, lat); end
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    wait_drain(ok);
    d = seq_diff();
    n_checks++; if (!ok || d != -1 || wb_empty !== 1'b1 || stable_err != 0) begin n_fail++;
      $display("FAIL wrap_order: got drained=%0d diff_idx=%0d empty=%b unstable=%0d expected 1/-1/1/0",
               ok, d, wb_empty, stable_err); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] rd, expd; bit ok; int d; bit is_rd;
    clear_scoreboard(); amode = 2;
    for (int i = 0; i < 24; i++) begin
      is_rd = ($urandom_range(0, 9) < 3);
      if (is_rd) begin
        next_rdata = $urandom; expd = next_rdata;
        do_req($urandom, 32'h0, 4'b0000, 1'($urandom_range(0, 1)), lat, rd);
        last_rdata = expd;
      end else begin
        expd = last_rdata;
        do_req($urandom, $urandom, 4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)), lat, rd);
      end
      n_checks++; if (lat < 1 || rd !== expd) begin n_fail++;
        $display("FAIL b2b_op_%0d: got lat=%0d rdata=%h expected >=1/%h", i, lat, rd, expd); end
    end
    wait_drain(ok);
    d = seq_diff();
    n_checks++; if (!ok || d != -1 || spacing_err != 0 || pulse_err != 0 || max_count > 4) begin n_fail++;
      $display("FAIL b2b_order: got drained=%0d diff_idx=%0d spacing=%0d pulses=%0d max=%0d expected 1/-1/0/0/<=4",
               ok, d, spacing_err, pulse_err, max_count); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rd; int n0;
    clear_scoreboard(); amode = 0;
    for (int i = 0; i < 3; i++) do_req($urandom, $urandom, 4'b1111, 1'b0, lat, rd);
    repeat (2) @(posedge clk); #1;
    n_checks++; if (dn_mem_valid !== 1'b1 || wb_count !== CW'(3)) begin n_fail++;
      $display("FAIL rm_pre: got valid=%b count=%0d expected 1/3", dn_mem_valid, wb_count); end
    #2 resetn = 1'b0;
    #1;
    n_checks++; if (dn_mem_valid !== 1'b0 || up_mem_ready !== 1'b0) begin n_fail++;
      $display("FAIL rm_async: got valid=%b ready=%b expected 0/0", dn_mem_valid, up_mem_ready); end
    @(posedge clk); #1 resetn = 1'b1;
    amode = 1; n0 = obs_q.size();
    repeat (12) @(posedge clk); #1;
    n_checks++; if (wb_count !== '0 || wb_empty !== 1'b1 || obs_q.size() != n0 || dn_mem_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rm_post: got count=%0d empty=%b new_txns=%0d valid=%b expected 0/1/0/0",
               wb_count, wb_empty, obs_q.size() - n0, dn_mem_valid); end
  endtask

  initial begin
    test_reset();
    test_write_stalled();
    test_fill_full();
    test_read_after_write();
    test_read_empty();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
